// File: rtl/secded_codec_engine_if.sv
// Memory-side bus of the SECDED codec engine: one combinational read port
// and one synchronous write port onto dat_mem.
interface secded_codec_engine_if #(
  parameter int unsigned W  = 8,
  parameter int unsigned AW = 8
);
  logic [AW-1:0] raddr;
  logic [W-1:0]  data_out;
  logic [AW-1:0] waddr;
  logic [W-1:0]  data_in;
  logic          write_en;

  // Engine side drives addresses and write data
  modport master (
    output raddr,
    output waddr,
    output data_in,
    output write_en,
    input  data_out
  );

  // Memory side returns read data
  modport slave (
    input  raddr,
    input  waddr,
    input  data_in,
    input  write_en,
    output data_out
  );
endinterface

// File: rtl/secded_codec_engine.sv
// Memory-to-memory Hamming(16,11) SECDED engine. Walks MSG_COUNT two-byte
// records from SRC_BASE and writes two-byte results to DST_BASE, either
// encoding 11 data bits or decoding/correcting a 16-bit codeword.
// Optional: define SECDED_ERR_COUNT_EN to enable the saturating
// err_single / err_double counters (otherwise both read as zero).
module secded_codec_engine #(
  parameter int unsigned W          = 8,
  parameter int unsigned BYTE_COUNT = 256,
  parameter int unsigned MSG_COUNT  = 15,
  parameter int unsigned SRC_BASE   = 0,
  parameter int unsigned DST_BASE   = 30
) (
  input  logic                   clk,
  input  logic                   init,
  input  logic                   mode,
  secded_codec_engine_if.master  mem_if,
  output logic                   done,
  output logic [7:0]             err_single,
  output logic [7:0]             err_double
);

  localparam int unsigned AW = $clog2(BYTE_COUNT);
  localparam int unsigned IW = (MSG_COUNT > 1) ? $clog2(MSG_COUNT) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(MSG_COUNT - 1);

  typedef enum logic [2:0] {
    S_LOAD_LO,
    S_LOAD_HI,
    S_COMPUTE,
    S_STORE_LO,
    S_STORE_HI,
    S_DONE
  } state_t;

  localparam state_t RESET_STATE = (MSG_COUNT == 0) ? S_DONE : S_LOAD_LO;

  state_t        r_state;
  logic [IW-1:0] r_idx;
  logic [AW-1:0] r_off;       // 2*i, modulo memory depth
  logic [W-1:0]  r_lo;
  logic [W-1:0]  r_hi;
  logic [7:0]    r_res_hi;
  logic          r_mode;
  logic          r_done;
  logic          r_we;
  logic [AW-1:0] r_waddr;
  logic [W-1:0]  r_wdata;

  logic [AW-1:0]  w_src_addr;
  logic [AW-1:0]  w_dst_addr;
  logic [10:0]    w_d;
  logic [15:0]    w_enc_np;
  logic [15:0]    w_enc;
  logic [2*W-1:0] w_code;
  logic [3:0]     w_syn;
  logic           w_gpar;
  logic [15:0]    w_fix;
  logic [1:0]     w_status;
  logic [15:0]    w_dec;
  logic [15:0]    w_result;

  // Record addresses for the current message index
  assign w_src_addr = AW'(SRC_BASE) + r_off;
  assign w_dst_addr = AW'(DST_BASE) + r_off;

  // Read address follows the state so data_out is valid within the load cycle
  assign mem_if.raddr    = (r_state == S_LOAD_HI) ? w_src_addr + AW'(1) : w_src_addr;
  assign mem_if.waddr    = r_waddr;
  assign mem_if.data_in  = r_wdata;
  assign mem_if.write_en = r_we;
  assign done            = r_done;

  // Encoder: data bits at non-power-of-two positions, parity over covered bits
  assign w_d      = {r_hi[2:0], r_lo};
  assign w_enc_np = {w_d[10:4],
                     ^{w_d[10], w_d[9], w_d[8], w_d[7], w_d[6], w_d[5], w_d[4]},
                     w_d[3:1],
                     ^{w_d[10], w_d[9], w_d[8], w_d[7], w_d[3], w_d[2], w_d[1]},
                     w_d[0],
                     ^{w_d[10], w_d[9], w_d[6], w_d[5], w_d[3], w_d[2], w_d[0]},
                     ^{w_d[10], w_d[8], w_d[6], w_d[4], w_d[3], w_d[1], w_d[0]},
                     1'b0};
  assign w_enc    = {w_enc_np[15:1], ^w_enc_np[15:1]};

  // Decoder: syndrome is the XOR of the indices of all set bits
  assign w_code = {r_hi, r_lo};
  assign w_gpar = ^w_code;

  always_comb begin
    w_syn = 4'd0;
    for (int j = 1; j < 16; j++) begin
      if (w_code[j]) w_syn = w_syn ^ 4'(j);
    end
  end

  // Overall parity decides single (correctable) versus double error
  always_comb begin
    w_fix    = w_code;
    w_status = 2'b00;
    if (w_gpar) begin
      w_fix    = w_code ^ (16'(1) << w_syn);
      w_status = 2'b01;
    end else if (w_syn != 4'd0) begin
      w_status = 2'b10;
    end
  end

  assign w_dec    = {w_status, 3'b000, w_fix[15:13], w_fix[12:9], w_fix[7:5], w_fix[3]};
  assign w_result = r_mode ? w_dec : w_enc;

  // Record sequencer with registered memory-write outputs
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      r_state  <= RESET_STATE;
      r_idx    <= '0;
      r_off    <= '0;
      r_lo     <= '0;
      r_hi     <= '0;
      r_res_hi <= '0;
      r_mode   <= 1'b0;
      r_done   <= (MSG_COUNT == 0);
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
    end else begin
      case (r_state)
        S_LOAD_LO: begin
          r_lo <= mem_if.data_out;
          if (r_idx == '0) r_mode <= mode;
          r_state <= S_LOAD_HI;
        end
        S_LOAD_HI: begin
          r_hi    <= mem_if.data_out;
          r_state <= S_COMPUTE;
        end
        S_COMPUTE: begin
          r_res_hi <= w_result[15:8];
          r_wdata  <= w_result[7:0];
          r_waddr  <= w_dst_addr;
          r_we     <= 1'b1;
          r_state  <= S_STORE_LO;
        end
        S_STORE_LO: begin
          r_wdata <= r_res_hi;
          r_waddr <= w_dst_addr + AW'(1);
          r_state <= S_STORE_HI;
        end
        S_STORE_HI: begin
          r_we <= 1'b0;
          if (r_idx == LAST_IDX) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx   <= r_idx + IW'(1);
            r_off   <= r_off + AW'(2);
            r_state <= S_LOAD_LO;
          end
        end
        default: begin
          r_state <= S_DONE;
        end
      endcase
    end
  end

`ifdef SECDED_ERR_COUNT_EN
  logic [7:0] r_err_single;
  logic [7:0] r_err_double;

  // Saturating error counters, updated when a decoded result is registered
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      r_err_single <= 8'd0;
      r_err_double <= 8'd0;
    end else if ((r_state == S_COMPUTE) && r_mode) begin
      if ((w_status == 2'b01) && (r_err_single != 8'hFF)) r_err_single <= r_err_single + 8'd1;
      if ((w_status == 2'b10) && (r_err_double != 8'hFF)) r_err_double <= r_err_double + 8'd1;
    end
  end

  assign err_single = r_err_single;
  assign err_double = r_err_double;
`else
  assign err_single = 8'd0;
  assign err_double = 8'd0;
`endif

endmodule

// File: tb/tb_secded_codec_engine.sv
// Directed bench for secded_codec_engine: encode, decode, address wrap,
// mid-run abort and the empty-run configuration.
module tb_secded_codec_engine;

`ifdef SECDED_ERR_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // DUT A: two records, default bases
  logic init_a = 1'b1, mode_a = 1'b0, done_a;
  logic [7:0] es_a, ed_a;
  secded_codec_engine_if #(.W(8), .AW(8)) bus_a ();
  secded_codec_engine #(.MSG_COUNT(2)) u_a (
    .clk(clk), .init(init_a), .mode(mode_a), .mem_if(bus_a),
    .done(done_a), .err_single(es_a), .err_double(ed_a));

  // DUT B: two records, destination wraps past the top of memory
  logic init_b = 1'b1, mode_b = 1'b0, done_b;
  logic [7:0] es_b, ed_b;
  secded_codec_engine_if #(.W(8), .AW(8)) bus_b ();
  secded_codec_engine #(.MSG_COUNT(2), .SRC_BASE(10), .DST_BASE(254)) u_b (
    .clk(clk), .init(init_b), .mode(mode_b), .mem_if(bus_b),
    .done(done_b), .err_single(es_b), .err_double(ed_b));

  // DUT C: no records at all
  logic init_c = 1'b1, mode_c = 1'b0, done_c;
  logic [7:0] es_c, ed_c;
  secded_codec_engine_if #(.W(8), .AW(8)) bus_c ();
  secded_codec_engine #(.MSG_COUNT(0)) u_c (
    .clk(clk), .init(init_c), .mode(mode_c), .mem_if(bus_c),
    .done(done_c), .err_single(es_c), .err_double(ed_c));

  // Memory models: source images read combinationally, results captured on write
  logic [7:0] src_a [256];
  logic [7:0] src_b [256];
  logic [7:0] src_c [256];
  logic [7:0] out_a [256];
  logic [7:0] out_b [256];
  int wcnt_a = 0, wcnt_b = 0, wcnt_c = 0;

  assign bus_a.data_out = src_a[bus_a.raddr];
  assign bus_b.data_out = src_b[bus_b.raddr];
  assign bus_c.data_out = src_c[bus_c.raddr];

  always @(posedge clk) begin
    if (bus_a.write_en) begin
      out_a[bus_a.waddr] <= bus_a.data_in;
      wcnt_a <= wcnt_a + 1;
    end
    if (bus_b.write_en) begin
      out_b[bus_b.waddr] <= bus_b.data_in;
      wcnt_b <= wcnt_b + 1;
    end
    if (bus_c.write_en) wcnt_c <= wcnt_c + 1;
  end

  // Reset DUT A, release it and count cycles until done (bounded)
  task automatic run_a(input logic m, input bit toggle, output int cyc);
    @(negedge clk);
    init_a = 1'b1;
    mode_a = m;
    @(negedge clk);
    init_a = 1'b0;
    cyc = 0;
    while (!done_a && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (toggle && cyc == 2) mode_a = ~m;
    end
  endtask

  task automatic test_reset();
    logic [7:0] exp_zero;
    exp_zero = 8'h00;
    init_a = 1'b1; init_b = 1'b1; init_c = 1'b1;
    repeat (2) @(negedge clk);
    n_total++; if (done_a !== 1'b0) $display("FAIL reset_done got=%b exp=0", done_a); else n_pass++;
    n_total++; if (bus_a.write_en !== 1'b0) $display("FAIL reset_we got=%b exp=0", bus_a.write_en); else n_pass++;
    n_total++; if (bus_a.raddr !== exp_zero) $display("FAIL reset_raddr got=%h exp=00", bus_a.raddr); else n_pass++;
    n_total++; if (bus_a.waddr !== exp_zero) $display("FAIL reset_waddr got=%h exp=00", bus_a.waddr); else n_pass++;
    n_total++; if (bus_a.data_in !== exp_zero) $display("FAIL reset_data_in got=%h exp=00", bus_a.data_in); else n_pass++;
    n_total++; if (es_a !== exp_zero) $display("FAIL reset_err_single got=%h exp=00", es_a); else n_pass++;
    n_total++; if (ed_a !== exp_zero) $display("FAIL reset_err_double got=%h exp=00", ed_a); else n_pass++;
  endtask

  task automatic test_encode();
    int cyc, w0;
    logic [7:0] exp1 [4];
    logic [7:0] exp2 [4];
    exp1 = '{8'h00, 8'h00, 8'hFF, 8'hFF};
    exp2 = '{8'h0F, 8'h00, 8'h00, 8'h00};
    src_a[0] = 8'h00; src_a[1] = 8'h00; src_a[2] = 8'hFF; src_a[3] = 8'h07;
    w0 = wcnt_a;
    run_a(1'b0, 1'b0, cyc);
    n_total++; if (cyc !== 10) $display("FAIL enc_done_cycle got=%0d exp=10", cyc); else n_pass++;
    n_total++; if (wcnt_a - w0 !== 4) $display("FAIL enc_write_cycles got=%0d exp=4", wcnt_a - w0); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (out_a[30 + k] !== exp1[k]) $display("FAIL enc_byte%0d got=%h exp=%h", 30 + k, out_a[30 + k], exp1[k]);
      else n_pass++;
    end
    // Record {01,00} encodes to 0x000F; hi[7:3] of {00,F8} must be ignored
    src_a[0] = 8'h01; src_a[1] = 8'h00; src_a[2] = 8'h00; src_a[3] = 8'hF8;
    run_a(1'b0, 1'b0, cyc);
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (out_a[30 + k] !== exp2[k]) $display("FAIL enc2_byte%0d got=%h exp=%h", 30 + k, out_a[30 + k], exp2[k]);
      else n_pass++;
    end
  endtask

  task automatic test_decode();
    int cyc, w0;
    logic [7:0] exp1 [4];
    logic [7:0] exp2 [4];
    logic [7:0] exp_cnt;
    exp1 = '{8'hFF, 8'h47, 8'hFF, 8'h87};
    exp2 = '{8'hFF, 8'h07, 8'hFF, 8'h07};
    exp_cnt = CNT_EN ? 8'd1 : 8'd0;
    // Single error at bit 5, then double error at bits 0 and 1; mode toggles mid-run
    src_a[0] = 8'hDF; src_a[1] = 8'hFF; src_a[2] = 8'hFC; src_a[3] = 8'hFF;
    w0 = wcnt_a;
    run_a(1'b1, 1'b1, cyc);
    n_total++; if (cyc !== 10) $display("FAIL dec_done_cycle got=%0d exp=10", cyc); else n_pass++;
    n_total++; if (wcnt_a - w0 !== 4) $display("FAIL dec_write_cycles got=%0d exp=4", wcnt_a - w0); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (out_a[30 + k] !== exp1[k]) $display("FAIL dec_byte%0d got=%h exp=%h", 30 + k, out_a[30 + k], exp1[k]);
      else n_pass++;
    end
    n_total++; if (es_a !== exp_cnt) $display("FAIL dec_err_single got=%h exp=%h", es_a, exp_cnt); else n_pass++;
    n_total++; if (ed_a !== exp_cnt) $display("FAIL dec_err_double got=%h exp=%h", ed_a, exp_cnt); else n_pass++;
    // Clean codewords: status 00, counters cleared by init and stay zero
    src_a[0] = 8'hFF; src_a[1] = 8'hFF; src_a[2] = 8'hFF; src_a[3] = 8'hFF;
    run_a(1'b1, 1'b0, cyc);
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (out_a[30 + k] !== exp2[k]) $display("FAIL clean_byte%0d got=%h exp=%h", 30 + k, out_a[30 + k], exp2[k]);
      else n_pass++;
    end
    n_total++; if (es_a !== 8'd0) $display("FAIL clean_err_single got=%h exp=00", es_a); else n_pass++;
    n_total++; if (ed_a !== 8'd0) $display("FAIL clean_err_double got=%h exp=00", ed_a); else n_pass++;
  endtask

  task automatic test_wrap();
    int cyc, w0;
    int addr [4];
    logic [7:0] expv [4];
    addr = '{254, 255, 0, 1};
    expv = '{8'h0F, 8'h00, 8'hFF, 8'hFF};
    src_b[10] = 8'h01; src_b[11] = 8'h00; src_b[12] = 8'hFF; src_b[13] = 8'h07;
    w0 = wcnt_b;
    @(negedge clk);
    init_b = 1'b1;
    mode_b = 1'b0;
    @(negedge clk);
    init_b = 1'b0;
    cyc = 0;
    while (!done_b && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    n_total++; if (cyc !== 10) $display("FAIL wrap_done_cycle got=%0d exp=10", cyc); else n_pass++;
    n_total++; if (wcnt_b - w0 !== 4) $display("FAIL wrap_write_cycles got=%0d exp=4", wcnt_b - w0); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (out_b[addr[k]] !== expv[k]) $display("FAIL wrap_byte%0d got=%h exp=%h", addr[k], out_b[addr[k]], expv[k]);
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    int cyc, w0;
    logic [7:0] exp_wa;
    logic [7:0] expv [4];
    exp_wa = 8'd32;
    expv = '{8'h00, 8'h00, 8'hFF, 8'hFF};
    src_a[0] = 8'h00; src_a[1] = 8'h00; src_a[2] = 8'hFF; src_a[3] = 8'h07;
    @(negedge clk);
    init_a = 1'b1;
    mode_a = 1'b0;
    @(negedge clk);
    init_a = 1'b0;
    w0 = wcnt_a;
    repeat (8) @(negedge clk);
    // Second record is now in STORE_LO
    n_total++; if (bus_a.write_en !== 1'b1) $display("FAIL abort_pre_we got=%b exp=1", bus_a.write_en); else n_pass++;
    n_total++; if (bus_a.waddr !== exp_wa) $display("FAIL abort_pre_waddr got=%h exp=%h", bus_a.waddr, exp_wa); else n_pass++;
    n_total++; if (bus_a.data_in !== 8'hFF) $display("FAIL abort_pre_data got=%h exp=ff", bus_a.data_in); else n_pass++;
    init_a = 1'b1;
    #1;
    n_total++; if (bus_a.write_en !== 1'b0) $display("FAIL abort_we got=%b exp=0", bus_a.write_en); else n_pass++;
    n_total++; if (done_a !== 1'b0) $display("FAIL abort_done got=%b exp=0", done_a); else n_pass++;
    repeat (3) @(negedge clk);
    n_total++; if (wcnt_a - w0 !== 2) $display("FAIL abort_writes got=%0d exp=2", wcnt_a - w0); else n_pass++;
    run_a(1'b0, 1'b0, cyc);
    n_total++; if (cyc !== 10) $display("FAIL rerun_done_cycle got=%0d exp=10", cyc); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (out_a[30 + k] !== expv[k]) $display("FAIL rerun_byte%0d got=%h exp=%h", 30 + k, out_a[30 + k], expv[k]);
      else n_pass++;
    end
  endtask

  task automatic test_zero();
    int w0;
    w0 = wcnt_c;
    @(negedge clk);
    init_c = 1'b1;
    @(negedge clk);
    init_c = 1'b0;
    #1;
    n_total++; if (done_c !== 1'b1) $display("FAIL zero_done_now got=%b exp=1", done_c); else n_pass++;
    repeat (6) @(negedge clk);
    n_total++; if (done_c !== 1'b1) $display("FAIL zero_done_hold got=%b exp=1", done_c); else n_pass++;
    n_total++; if (wcnt_c - w0 !== 0) $display("FAIL zero_writes got=%0d exp=0", wcnt_c - w0); else n_pass++;
  endtask

  initial begin
    for (int k = 0; k < 256; k++) begin
      src_a[k] = 8'h00;
      src_b[k] = 8'h00;
      src_c[k] = 8'h00;
    end
    test_reset();
    test_encode();
    test_decode();
    test_wrap();
    test_abort();
    test_zero();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard stop if something wedges outside the bounded loops
  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/secded_codec_engine.md
Name: secded_codec_engine

Overview:
- Parametrised memory-to-memory SECDED engine: successor to the Lab 4 fixed 15-message Hamming(15,11) transmitter.
- Adds configurable message count and base addresses, plus a decode (receiver) mode that corrects single-bit errors and flags double-bit errors.
- Sits beside dat_mem under top-level control.
- Walks MSG_COUNT two-byte records from SRC_BASE and writes two-byte results to DST_BASE.

Parameters:
- W, 8, memory word width; must be 8.
- BYTE_COUNT, 256, memory depth; address width AW = $clog2(BYTE_COUNT).
- MSG_COUNT, 15, number of two-byte records processed; 0 is legal.
- SRC_BASE, 0, byte address of the first source record.
- DST_BASE, 30, byte address of the first result record.

Ports:
- clk  in  1  clock.
- init  in  1  reset; asynchronous, active-high; processing starts on deassertion.
- mode  in  1  0 = encode, 1 = decode; captured once per run.
- raddr  out  AW  memory read address.
- data_out  in  W  memory read data, combinational from raddr.
- waddr  out  AW  memory write address.
- data_in  out  W  memory write data.
- write_en  out  1  memory store enable.
- done  out  1  run complete.
- err_single  out  8  count of corrected single errors (optional feature).
- err_double  out  8  count of detected double errors (optional feature).

Behaviour:
- Reset (init high, async):
  - state = LOAD_LO, message index i = 0, temps = 0, captured mode = 0.
  - done = 0, write_en = 0, raddr = waddr = 0, data_in = 0, counters = 0.
- States, one cycle each: LOAD_LO → LOAD_HI → COMPUTE → STORE_LO → STORE_HI.
  - STORE_HI goes to LOAD_LO with i+1 if i < MSG_COUNT−1, else to DONE.
  - DONE holds until init.
  - MSG_COUNT = 0: reset state is DONE.
- LOAD_LO:
  - raddr = SRC_BASE + 2i; latch lo byte.
  - When i = 0, also capture mode; mode changes mid-run are ignored.
- LOAD_HI: raddr = SRC_BASE + 2i + 1; latch hi byte.
- COMPUTE: register the 16-bit result.
- STORE_LO: write_en = 1, waddr = DST_BASE + 2i, data_in = result[7:0].
- STORE_HI: write_en = 1, waddr = DST_BASE + 2i + 1, data_in = result[15:8].
- write_en is 0 in all other states.
- Address arithmetic is modulo BYTE_COUNT and wraps silently.
- Latency:
  - 5 cycles per record.
  - done rises at the clock edge ending cycle 5·MSG_COUNT, counting cycle 1 as the first cycle after init falls.
- Codeword bit layout, c[15:0]:
  - c[15:9] = d[10:4], c[8] = p8, c[7:5] = d[3:1], c[4] = p4, c[3] = d[0], c[2] = p2, c[1] = p1, c[0] = p0.
  - pk (k = 1, 2, 4, 8) = XOR of c[j] for j in 3..15 with j&k ≠ 0.
  - p0 = XOR of c[15:1].
- Encode:
  - d[10:0] = {hi[2:0], lo[7:0]}; hi[7:3] is ignored.
  - result = c.
- Decode:
  - Syndrome S[3:0] = XOR of indices j (1..15) where c[j] = 1.
  - G = XOR of c[15:0].
  - S = 0, G = 0: status 00, no change.
  - G = 1: single error; flip c[S] (S = 0 flips p0); status 01.
  - S ≠ 0, G = 0: double error; data left uncorrected; status 10.
  - result lo = d[7:0]; result hi = {status[1:0], 3'b000, d[10:8]}.
- init asserted mid-run: all state and outputs return to reset values immediately.
  - The write in progress is dropped; no partial-cycle write.

Optional Feature:
- SECDED_ERR_COUNT_EN defined:
  - err_single / err_double increment in COMPUTE on decode status 01 / 10.
  - Both saturate at 255; both cleared by init.
- Not defined: both ports present and tied to 0.

Test Plan:
- Encode, MSG_COUNT = 2; src bytes {00,00} and {FF,07} → dst[30..33] = 00,00,FF,FF; done rises at cycle 10; write_en high exactly 4 cycles.
- Decode, record {DF,FF} (0xFFDF, bit 5 flipped) → result lo = FF, hi = 0x47; err_single = 1 when the feature is enabled.
- Decode, record {FC,FF} (bits 0 and 1 flipped) → lo = FF, hi = 0x87; err_double = 1.
- Decode, clean record {FF,FF} → lo = FF, hi = 0x07; both counters stay 0.
- DST_BASE = 254, MSG_COUNT = 2 → writes land at 254, 255, 0, 1 (wrap).
- Assert init during STORE_LO of record 1 → write_en drops the same cycle, done = 0; after release, rerun completes with correct outputs. Separately, MSG_COUNT = 0 → done = 1 immediately after reset, with no writes.
